// File: rtl/calc_display_fmt.sv
// Formats a 27-bit unsigned result into eight 4-bit digit codes (decimal via
// iterative double-dabble, or hex), with leading-zero blanking and dot enables.
module calc_display_fmt #(
    parameter bit LZ_BLANK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [26:0] value,
    input  logic        hex_mode,
    input  logic [3:0]  dot_pos,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [3:0]  seg_data_1,
    output logic [3:0]  seg_data_2,
    output logic [3:0]  seg_data_3,
    output logic [3:0]  seg_data_4,
    output logic [3:0]  seg_data_5,
    output logic [3:0]  seg_data_6,
    output logic [3:0]  seg_data_7,
    output logic [3:0]  seg_data_8,
    output logic [7:0]  seg_data_en,
    output logic [7:0]  seg_dot_en
);

    typedef enum logic [1:0] {IDLE, CONV, FMT} state_t;

    localparam logic [26:0] DEC_MAX = 27'd99_999_999;

    state_t      state, state_nxt;
    logic [26:0] bin_sr;
    logic [31:0] bcd;
    logic        hex_r;
    logic [3:0]  dot_r;
    logic        ovf_r;
    logic [4:0]  cnt;
    logic        accept;
    logic [3:0]  dig_q   [8];
    logic [3:0]  dig_nxt [8];
    logic [7:0]  en_nxt;
    logic [7:0]  dot_nxt;
    logic        nz_any;
    logic        dot_valid;

    function automatic logic [31:0] dabble_adj(input logic [31:0] b);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < 8; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    assign accept = (state == IDLE) && load;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load) state_nxt = (!hex_mode && value <= DEC_MAX) ? CONV : FMT;
            CONV: if (cnt == 5'd26) state_nxt = FMT;
            FMT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Formatting of the latched result; consumed only on the FMT edge.
    always_comb begin
        nz_any    = 1'b0;
        dot_valid = (dot_r >= 4'd1) && (dot_r <= 4'd8);
        en_nxt    = 8'h00;
        dot_nxt   = 8'h00;
        for (int k = 0; k < 8; k++) begin
            dig_nxt[k] = hex_r ? ({1'b0, bin_sr} >> (4 * k)) & 28'hF : bcd[4*k +: 4];
            dot_nxt[k] = (dot_r == 4'(k + 1));
        end
        // Scan from the most significant digit so any nonzero digit lights all below it.
        for (int k = 7; k >= 0; k--) begin
            nz_any    = nz_any | (|dig_nxt[k]);
            en_nxt[k] = (k == 0) || nz_any || (dot_valid && dot_r >= 4'(k + 1));
        end
        if (!LZ_BLANK) en_nxt = 8'hFF;
        if (ovf_r) begin
            for (int k = 0; k < 8; k++) dig_nxt[k] = 4'hE;
            en_nxt  = 8'hFF;
            dot_nxt = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bin_sr <= value;
            bcd    <= 32'd0;
            hex_r  <= hex_mode;
            dot_r  <= dot_pos;
            ovf_r  <= !hex_mode && (value > DEC_MAX);
        end else if (state == CONV) begin
            {bcd, bin_sr} <= {dabble_adj(bcd), bin_sr} << 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            seg_data_en <= 8'h00;
            seg_dot_en  <= 8'h00;
            for (int k = 0; k < 8; k++) dig_q[k] <= 4'h0;
        end else begin
            state <= state_nxt;
            done  <= (state == FMT);
            if (accept) begin
                cnt  <= 5'd0;
                busy <= 1'b1;
            end else if (state == CONV) begin
                cnt <= cnt + 5'd1;
            end
            if (state == FMT) begin
                busy        <= 1'b0;
                overflow    <= ovf_r;
                seg_data_en <= en_nxt;
                seg_dot_en  <= dot_nxt;
                for (int k = 0; k < 8; k++) dig_q[k] <= dig_nxt[k];
            end
        end
    end

    assign seg_data_1 = dig_q[0];
    assign seg_data_2 = dig_q[1];
    assign seg_data_3 = dig_q[2];
    assign seg_data_4 = dig_q[3];
    assign seg_data_5 = dig_q[4];
    assign seg_data_6 = dig_q[5];
    assign seg_data_7 = dig_q[6];
    assign seg_data_8 = dig_q[7];

endmodule

// File: tb/tb_calc_display_fmt.sv
// Scoreboard bench for calc_display_fmt: blanking and non-blanking instances share stimulus.
module tb_calc_display_fmt;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [26:0] value = '0;
    logic        hex_mode = 1'b0;
    logic [3:0]  dot_pos = '0;

    logic       busy, done, overflow;
    logic [3:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic [7:0] en, dot;
    logic       busy0, done0, overflow0;
    logic [3:0] z1, z2, z3, z4, z5, z6, z7, z8;
    logic [7:0] en0, dot0;

    calc_display_fmt #(.LZ_BLANK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .hex_mode(hex_mode),
        .dot_pos(dot_pos), .busy(busy), .done(done), .overflow(overflow),
        .seg_data_1(d1), .seg_data_2(d2), .seg_data_3(d3), .seg_data_4(d4),
        .seg_data_5(d5), .seg_data_6(d6), .seg_data_7(d7), .seg_data_8(d8),
        .seg_data_en(en), .seg_dot_en(dot)
    );

    calc_display_fmt #(.LZ_BLANK(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .hex_mode(hex_mode),
        .dot_pos(dot_pos), .busy(busy0), .done(done0), .overflow(overflow0),
        .seg_data_1(z1), .seg_data_2(z2), .seg_data_3(z3), .seg_data_4(z4),
        .seg_data_5(z5), .seg_data_6(z6), .seg_data_7(z7), .seg_data_8(z8),
        .seg_data_en(en0), .seg_dot_en(dot0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dig;
        logic [7:0]  en;
        logic [7:0]  dot;
        logic        ovf;
        int          lat;
        int          load_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [26:0] v, input logic hx, input logic [3:0] dp);
        exp_t e;
        int unsigned tmp;
        int msd;
        e.ovf = !hx && (v > 27'd99_999_999);
        e.dig = '0;
        e.dot = (dp >= 4'd1 && dp <= 4'd8) ? (8'd1 << (dp - 4'd1)) : 8'h00;
        e.lat = (hx || e.ovf) ? 1 : 28;
        e.load_cyc = 0;
        if (e.ovf) begin
            e.dig = 32'hEEEE_EEEE;
            e.en  = 8'hFF;
            e.dot = 8'h00;
            return e;
        end
        tmp = v;
        for (int k = 0; k < 8; k++) begin
            if (hx) begin
                e.dig[4*k +: 4] = 4'(tmp & 15);
                tmp = tmp >> 4;
            end else begin
                e.dig[4*k +: 4] = 4'(tmp % 10);
                tmp = tmp / 10;
            end
        end
        msd = 0;
        for (int k = 0; k < 8; k++) if (e.dig[4*k +: 4] != 4'h0) msd = k;
        for (int k = 0; k < 8; k++)
            e.en[k] = (k <= msd) || (dp >= 4'd1 && dp <= 4'd8 && int'(dp) - 1 >= k);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && (done || done0)) begin
            if (sb.size() == 0) begin
                check("spurious_done", {63'd0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("digits", {d8, d7, d6, d5, d4, d3, d2, d1}, e.dig);
                check("en", en, e.en);
                check("dot", dot, e.dot);
                check("overflow", overflow, e.ovf);
                check("latency", cyc - e.load_cyc, e.lat);
                check("busy_at_done", busy, 0);
                check("done0", done0, 1);
                check("digits_nolz", {z8, z7, z6, z5, z4, z3, z2, z1}, e.dig);
                check("en_nolz", en0, 8'hFF);
                check("dot_nolz", dot0, e.dot);
            end
        end
    end

    // Called right after a falling edge; leaves the bench just after the next one.
    task automatic do_load(input logic [26:0] v, input logic hx, input logic [3:0] dp,
                           input bit expect_accept);
        exp_t e;
        value = v; hex_mode = hx; dot_pos = dp; load = 1'b1;
        if (expect_accept) begin
            e = model(v, hx, dp);
            e.load_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_en"}, en, 8'h00);
        check({tag, "_dot"}, dot, 8'h00);
        check({tag, "_digits"}, {d8, d7, d6, d5, d4, d3, d2, d1}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("rst_init");
        rst_n = 1'b1;
        @(negedge clk); #1;

        do_load(27'd12345, 1'b0, 4'd0, 1'b1);      wait_empty();
        do_load(27'd0, 1'b0, 4'd3, 1'b1);          wait_empty();
        do_load(27'd99_999_999, 1'b0, 4'd0, 1'b1); wait_empty();
        do_load(27'd100_000_000, 1'b0, 4'd2, 1'b1); wait_empty();
        do_load(27'h00A0F3, 1'b1, 4'd0, 1'b1);     wait_empty();
        do_load(27'd123, 1'b0, 4'd5, 1'b1);        wait_empty();
        do_load(27'h7FF_FFFF, 1'b1, 4'd8, 1'b1);   wait_empty();
        do_load(27'd134_217_727, 1'b0, 4'd1, 1'b1); wait_empty();

        // Loads while busy are dropped; a load right after done is taken.
        do_load(27'd12345, 1'b0, 4'd0, 1'b1);
        repeat (8) begin @(negedge clk); #1; end
        check("busy_mid", busy, 1);
        do_load(27'd777, 1'b0, 4'd0, 1'b0);
        wait_empty();
        do_load(27'd777, 1'b0, 4'd2, 1'b1);        wait_empty();

        for (int i = 0; i < 6; i++) begin
            do_load(27'($urandom_range(0, 99_999_999)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 1'b1);
            wait_empty();
        end

        // Reset in the middle of a conversion, after an overflow left state behind.
        do_load(27'd100_000_001, 1'b0, 4'd0, 1'b1); wait_empty();
        do_load(27'd54321, 1'b0, 4'd4, 1'b0);
        repeat (8) begin @(negedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        repeat (2) begin @(negedge clk); #1; end
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); #1; end
        check_reset_state("rst_after");

        do_load(27'd42, 1'b0, 4'd0, 1'b1);         wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
